// File: rtl/memory_access_stage.sv
// Pipeline MEM stage: runs loads/stores over a req/ack data-memory port, aligns store
// data, extends load data, and drives the registered write-back pipe register.
module memory_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      exValid,
    input  logic                      exIsLoad,
    input  logic                      exIsStore,
    input  logic [1:0]                exMemSize,
    input  logic                      exUnsigned,
    input  logic [DATA_WIDTH-1:0]     exAddr,
    input  logic [DATA_WIDTH-1:0]     exStoreData,
    input  logic                      exRdWrite,
    input  logic [REG_ADDR_WIDTH-1:0] exRdAddr,
    input  logic                      flush,
    output logic                      stall,
    output logic                      dmemReq,
    output logic                      dmemWe,
    output logic [DATA_WIDTH-1:0]     dmemAddr,
    output logic [DATA_WIDTH-1:0]     dmemWData,
    output logic [3:0]                dmemBe,
    input  logic                      dmemAck,
    input  logic [DATA_WIDTH-1:0]     dmemRData,
    output logic                      wbValid,
    output logic                      wbRdWrite,
    output logic [REG_ADDR_WIDTH-1:0] wbRdAddr,
    output logic [DATA_WIDTH-1:0]     wbData,
    output logic                      wbMisaligned
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                    state;
    logic                      isLoadQ;
    logic [1:0]                sizeQ;
    logic                      unsignedQ;
    logic [1:0]                addrLoQ;
    logic                      rdWriteQ;
    logic [REG_ADDR_WIDTH-1:0] rdAddrQ;
    logic                      killed;

    logic                  misaligned;
    logic [3:0]            beNext;
    logic [DATA_WIDTH-1:0] wdataNext;
    logic [7:0]            byteLane;
    logic [15:0]           halfLane;
    logic [DATA_WIDTH-1:0] loadData;

    assign stall = (state == BUSY);

    always_comb begin
        misaligned = 1'b0;
        beNext     = 4'b1111;
        wdataNext  = exStoreData;
        case (exMemSize)
            2'd0: begin
                beNext    = 4'b0001 << exAddr[1:0];
                wdataNext = {4{exStoreData[7:0]}};
            end
            2'd1: begin
                misaligned = exAddr[0];
                beNext     = 4'b0011 << exAddr[1:0];
                wdataNext  = {2{exStoreData[15:0]}};
            end
            2'd2:    misaligned = |exAddr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        byteLane = dmemRData[7:0];
        case (addrLoQ)
            2'd1:    byteLane = dmemRData[15:8];
            2'd2:    byteLane = dmemRData[23:16];
            2'd3:    byteLane = dmemRData[31:24];
            default: byteLane = dmemRData[7:0];
        endcase
        halfLane = addrLoQ[1] ? dmemRData[31:16] : dmemRData[15:0];
        case (sizeQ)
            2'd0:    loadData = unsignedQ ? {24'b0, byteLane} : {{24{byteLane[7]}}, byteLane};
            2'd1:    loadData = unsignedQ ? {16'b0, halfLane} : {{16{halfLane[15]}}, halfLane};
            default: loadData = dmemRData;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            isLoadQ      <= 1'b0;
            sizeQ        <= '0;
            unsignedQ    <= 1'b0;
            addrLoQ      <= '0;
            rdWriteQ     <= 1'b0;
            rdAddrQ      <= '0;
            killed       <= 1'b0;
            dmemReq      <= 1'b0;
            dmemWe       <= 1'b0;
            dmemAddr     <= '0;
            dmemWData    <= '0;
            dmemBe       <= '0;
            wbValid      <= 1'b0;
            wbRdWrite    <= 1'b0;
            wbRdAddr     <= '0;
            wbData       <= '0;
            wbMisaligned <= 1'b0;
        end else begin
            // wb register defaults to an empty slot; branches below override it
            wbValid      <= 1'b0;
            wbRdWrite    <= 1'b0;
            wbRdAddr     <= '0;
            wbData       <= '0;
            wbMisaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (exValid && !flush) begin
                        if (!(exIsLoad || exIsStore)) begin
                            wbValid   <= 1'b1;
                            wbRdWrite <= exRdWrite;
                            wbRdAddr  <= exRdAddr;
                            wbData    <= exAddr;
                        end else if (misaligned) begin
                            wbValid      <= 1'b1;
                            wbRdAddr     <= exRdAddr;
                            wbMisaligned <= 1'b1;
                        end else begin
                            isLoadQ   <= exIsLoad;
                            sizeQ     <= exMemSize;
                            unsignedQ <= exUnsigned;
                            addrLoQ   <= exAddr[1:0];
                            rdWriteQ  <= exRdWrite;
                            rdAddrQ   <= exRdAddr;
                            killed    <= 1'b0;
                            dmemReq   <= 1'b1;
                            dmemWe    <= exIsStore;
                            dmemAddr  <= {exAddr[DATA_WIDTH-1:2], 2'b00};
                            dmemWData <= wdataNext;
                            dmemBe    <= beNext;
                            state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) killed <= 1'b1;
                    if (dmemAck) begin
                        // the bus op always completes; a flush only discards its result
                        dmemReq <= 1'b0;
                        killed  <= 1'b0;
                        state   <= IDLE;
                        if (!(killed || flush)) begin
                            wbValid  <= 1'b1;
                            wbRdAddr <= rdAddrQ;
                            if (isLoadQ) begin
                                wbRdWrite <= rdWriteQ;
                                wbData    <= loadData;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed plan cases plus randomized
// operations checked against an arithmetic reference model.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        exValid, exIsLoad, exIsStore, exUnsigned, exRdWrite, flush;
    logic [1:0]  exMemSize;
    logic [31:0] exAddr, exStoreData;
    logic [4:0]  exRdAddr;
    logic        stall, dmemReq, dmemWe, dmemAck;
    logic [31:0] dmemAddr, dmemWData, dmemRData;
    logic [3:0]  dmemBe;
    logic        wbValid, wbRdWrite, wbMisaligned;
    logic [4:0]  wbRdAddr;
    logic [31:0] wbData;

    int unsigned nCmp = 0;
    int unsigned nBad = 0;

    typedef struct {
        bit        isLoad;
        bit        isStore;
        bit [1:0]  size;
        bit        uns;
        bit [31:0] addr;
        bit [31:0] data;
        bit        rdW;
        bit [4:0]  rd;
    } op_t;

    always #5 clk = ~clk;

    memory_access_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .exValid(exValid), .exIsLoad(exIsLoad), .exIsStore(exIsStore),
        .exMemSize(exMemSize), .exUnsigned(exUnsigned), .exAddr(exAddr),
        .exStoreData(exStoreData), .exRdWrite(exRdWrite), .exRdAddr(exRdAddr), .flush(flush),
        .stall(stall), .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
        .dmemWData(dmemWData), .dmemBe(dmemBe), .dmemAck(dmemAck), .dmemRData(dmemRData),
        .wbValid(wbValid), .wbRdWrite(wbRdWrite), .wbRdAddr(wbRdAddr), .wbData(wbData),
        .wbMisaligned(wbMisaligned)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned opBytes(input op_t o);
        return 1 << o.size;
    endfunction

    function automatic bit isBad(input op_t o);
        return (o.size == 2'd3) || ((o.addr % opBytes(o)) != 0);
    endfunction

    function automatic logic [3:0] expBe(input op_t o);
        logic [7:0] m;
        m = 8'((1 << opBytes(o)) - 1) << (o.addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] expWData(input op_t o);
        if (o.size == 2'd0) return (o.data & 32'hFF) * 32'h0101_0101;
        if (o.size == 2'd1) return (o.data & 32'hFFFF) * 32'h0001_0001;
        return o.data;
    endfunction

    function automatic logic [31:0] expLoad(input op_t o, input logic [31:0] rdata);
        int unsigned bits;
        logic [31:0] lane, mask, top;
        bits = 8 * opBytes(o);
        lane = rdata >> (8 * (o.addr % 4));
        if (bits == 32) return lane;
        mask = (32'd1 << bits) - 1;
        top  = 32'd1 << (bits - 1);
        lane = lane & mask;
        if (!o.uns && (lane & top) != 0) lane = lane | ~mask;
        return lane;
    endfunction

    function automatic op_t mkOp(input int kind, input bit [1:0] size, input bit uns,
                                 input bit [31:0] addr, input bit [31:0] data,
                                 input bit rdW, input bit [4:0] rd);
        op_t o;
        o.isLoad = (kind == 1); o.isStore = (kind == 2);
        o.size = size; o.uns = uns; o.addr = addr; o.data = data; o.rdW = rdW; o.rd = rd;
        return o;
    endfunction

    task automatic present(input op_t o);
        exValid = 1'b1; exIsLoad = o.isLoad; exIsStore = o.isStore; exMemSize = o.size;
        exUnsigned = o.uns; exAddr = o.addr; exStoreData = o.data; exRdWrite = o.rdW;
        exRdAddr = o.rd;
    endtask

    task automatic scramble();
        bit r;
        r = 1'($urandom);
        exValid = 1'($urandom); exIsLoad = r; exIsStore = ~r & 1'($urandom);
        exMemSize = 2'($urandom); exUnsigned = 1'($urandom); exAddr = $urandom;
        exStoreData = $urandom; exRdWrite = 1'($urandom); exRdAddr = 5'($urandom);
    endtask

    task automatic idleInputs();
        exValid = 1'b0; exIsLoad = 1'b0; exIsStore = 1'b0; exMemSize = '0; exUnsigned = 1'b0;
        exAddr = '0; exStoreData = '0; exRdWrite = 1'b0; exRdAddr = '0; flush = 1'b0;
        dmemAck = 1'b0; dmemRData = '0;
    endtask

    // One instruction end to end; k = ack cycle, flushAt = busy cycle carrying flush (0 = none)
    task automatic runOp(input string tag, input op_t o, input int k, input logic [31:0] rdata,
                         input int flushAt, input bit flushIdle);
        logic [31:0] memAddr;
        @(negedge clk);
        present(o);
        flush = flushIdle;
        dmemAck = 1'($urandom);
        dmemRData = $urandom;
        @(posedge clk); #1;
        if (flushIdle) begin
            checkEq({tag, ".flushIdle.wbValid"}, 32'(wbValid), 0);
            checkEq({tag, ".flushIdle.req"}, 32'(dmemReq), 0);
            checkEq({tag, ".flushIdle.stall"}, 32'(stall), 0);
            return;
        end
        if (!(o.isLoad || o.isStore)) begin
            checkEq({tag, ".alu.wbValid"}, 32'(wbValid), 1);
            checkEq({tag, ".alu.rdWrite"}, 32'(wbRdWrite), 32'(o.rdW));
            checkEq({tag, ".alu.rdAddr"}, 32'(wbRdAddr), 32'(o.rd));
            checkEq({tag, ".alu.data"}, wbData, o.addr);
            checkEq({tag, ".alu.mis"}, 32'(wbMisaligned), 0);
            checkEq({tag, ".alu.stall"}, 32'(stall), 0);
            return;
        end
        if (isBad(o)) begin
            checkEq({tag, ".mis.wbValid"}, 32'(wbValid), 1);
            checkEq({tag, ".mis.rdWrite"}, 32'(wbRdWrite), 0);
            checkEq({tag, ".mis.flag"}, 32'(wbMisaligned), 1);
            checkEq({tag, ".mis.req"}, 32'(dmemReq), 0);
            checkEq({tag, ".mis.stall"}, 32'(stall), 0);
            return;
        end
        memAddr = o.addr - (o.addr % 4);
        checkEq({tag, ".issue.stall"}, 32'(stall), 1);
        checkEq({tag, ".issue.wbValid"}, 32'(wbValid), 0);
        checkEq({tag, ".issue.req"}, 32'(dmemReq), 1);
        checkEq({tag, ".issue.we"}, 32'(dmemWe), 32'(o.isStore));
        checkEq({tag, ".issue.addr"}, dmemAddr, memAddr);
        checkEq({tag, ".issue.be"}, 32'(dmemBe), 32'(expBe(o)));
        if (o.isStore) checkEq({tag, ".issue.wdata"}, dmemWData, expWData(o));
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            scramble();
            flush = (i == flushAt);
            dmemAck = (i == k);
            dmemRData = (i == k) ? rdata : $urandom;
            @(posedge clk); #1;
            if (i < k) begin
                checkEq({tag, ".busy.stall"}, 32'(stall), 1);
                checkEq({tag, ".busy.wbValid"}, 32'(wbValid), 0);
                checkEq({tag, ".busy.req"}, 32'(dmemReq), 1);
                checkEq({tag, ".busy.addr"}, dmemAddr, memAddr);
                checkEq({tag, ".busy.be"}, 32'(dmemBe), 32'(expBe(o)));
            end
        end
        dmemAck = 1'b0;
        flush = 1'b0;
        exValid = 1'b0;
        checkEq({tag, ".done.stall"}, 32'(stall), 0);
        checkEq({tag, ".done.req"}, 32'(dmemReq), 0);
        if (flushAt != 0) begin
            checkEq({tag, ".killed.wbValid"}, 32'(wbValid), 0);
        end else begin
            checkEq({tag, ".done.wbValid"}, 32'(wbValid), 1);
            checkEq({tag, ".done.rdAddr"}, 32'(wbRdAddr), 32'(o.rd));
            checkEq({tag, ".done.rdWrite"}, 32'(wbRdWrite), o.isLoad ? 32'(o.rdW) : 0);
            checkEq({tag, ".done.data"}, wbData, o.isLoad ? expLoad(o, rdata) : 0);
            checkEq({tag, ".done.mis"}, 32'(wbMisaligned), 0);
        end
    endtask

    initial begin
        op_t o, alu;
        idleInputs();
        rst = 1'b0;
        #2;
        checkEq("reset.wbValid", 32'(wbValid), 0);
        checkEq("reset.stall", 32'(stall), 0);
        checkEq("reset.req", 32'(dmemReq), 0);
        checkEq("reset.wbData", wbData, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        runOp("aluOp", mkOp(0, 2'd0, 0, 32'h1234, 0, 1, 5'd5), 0, 0, 0, 0);
        runOp("lbSigned", mkOp(1, 2'd0, 0, 32'h103, 0, 1, 5'd7), 3, 32'h80AABBCC, 0, 0);
        runOp("lbUnsigned", mkOp(1, 2'd0, 1, 32'h103, 0, 1, 5'd7), 3, 32'h80AABBCC, 0, 0);
        runOp("shStore", mkOp(2, 2'd1, 0, 32'h202, 32'hDEADBEEF, 1, 5'd9), 2, 0, 0, 0);
        runOp("lwMis", mkOp(1, 2'd2, 0, 32'h301, 0, 1, 5'd3), 0, 0, 0, 0);
        runOp("lwWord", mkOp(1, 2'd2, 0, 32'h400, 0, 1, 5'd4), 1, 32'hCAFEF00D, 0, 0);

        // flush during BUSY with an ALU op held upstream behind the store
        alu = mkOp(0, 2'd0, 0, 32'hA5A5_0001, 0, 1, 5'd11);
        @(negedge clk);
        present(mkOp(2, 2'd2, 0, 32'h500, 32'h1122_3344, 0, 5'd1));
        @(posedge clk); #1;
        checkEq("flushBusy.issueReq", 32'(dmemReq), 1);
        @(negedge clk);
        present(alu); flush = 1'b1;
        @(posedge clk); #1;
        checkEq("flushBusy.req", 32'(dmemReq), 1);
        checkEq("flushBusy.stall", 32'(stall), 1);
        checkEq("flushBusy.wbValid", 32'(wbValid), 0);
        @(negedge clk);
        flush = 1'b0; dmemAck = 1'b1;
        @(posedge clk); #1;
        checkEq("flushBusy.ackWbValid", 32'(wbValid), 0);
        checkEq("flushBusy.ackReq", 32'(dmemReq), 0);
        checkEq("flushBusy.ackStall", 32'(stall), 0);
        @(negedge clk);
        dmemAck = 1'b0;
        @(posedge clk); #1;
        checkEq("heldAlu.wbValid", 32'(wbValid), 1);
        checkEq("heldAlu.data", wbData, alu.addr);
        checkEq("heldAlu.rdAddr", 32'(wbRdAddr), 32'(alu.rd));
        @(negedge clk);
        exValid = 1'b0;
        @(posedge clk); #1;
        checkEq("heldAlu.onePulse", 32'(wbValid), 0);

        // reset asserted mid-transaction acts without waiting for a clock edge
        @(negedge clk);
        present(mkOp(1, 2'd2, 0, 32'h600, 0, 1, 5'd2));
        @(posedge clk); #1;
        checkEq("midReset.req", 32'(dmemReq), 1);
        exValid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkEq("midReset.reqLow", 32'(dmemReq), 0);
        checkEq("midReset.stallLow", 32'(stall), 0);
        checkEq("midReset.wbValid", 32'(wbValid), 0);
        checkEq("midReset.wbData", wbData, 0);
        @(negedge clk);
        rst = 1'b1;
        runOp("postReset", mkOp(1, 2'd1, 0, 32'h602, 0, 1, 5'd6), 2, 32'h8001_7FFF, 0, 0);

        for (int n = 0; n < 200; n++) begin
            int kind, k, fAt;
            bit fIdle;
            kind = $urandom_range(0, 2);
            o = mkOp(kind, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                     1'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) != 0) o.addr = o.addr - (o.addr % opBytes(o));
            k = $urandom_range(1, 4);
            fAt = ($urandom_range(0, 4) == 0) ? $urandom_range(1, k) : 0;
            fIdle = ($urandom_range(0, 9) == 0);
            runOp("rand", o, k, $urandom, fAt, fIdle);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline MEM stage sitting between the execute stage and the write-back stage. It runs loads and stores against the data-memory port using a req/ack handshake, and stalls upstream while a transaction is outstanding. It aligns store data and generates byte enables, and sign- or zero-extends load data. Its output is the registered write-back pipe register consumed by the write-back stage and by the controller's forwarding and hazard logic.

## Interface
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- REG_ADDR_WIDTH, 5, register-file address width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- exValid  in  1  execute stage presents an instruction.
- exIsLoad / exIsStore  in  1 each  memory op type; never both 1.
- exMemSize  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- exUnsigned  in  1  load zero-extends when 1.
- exAddr  in  32  memory address, or the ALU result for non-memory ops.
- exStoreData  in  32  store source register value.
- exRdWrite  in  1  destination register write enable.
- exRdAddr  in  5  destination register address.
- flush  in  1  kill the current or incoming instruction.
- stall  out  1  upstream must hold its ex* inputs stable.
- dmemReq  out  1  memory request, held until ack.
- dmemWe  out  1  1 = store.
- dmemAddr  out  32  word address with {exAddr[31:2], 2'b00}.
- dmemWData  out  32  lane-replicated store data.
- dmemBe  out  4  byte enables.
- dmemAck  in  1  transaction complete; dmemRData is valid in the same cycle.
- dmemRData  in  32  read word.
- wbValid, wbRdWrite  out  1 each  write-back pipe register fields.
- wbRdAddr  out  5  write-back destination register.
- wbData  out  32  write-back data.
- wbMisaligned  out  1  access fault flag.

## Operation
- FSM has two states, IDLE and BUSY. Reset enters IDLE.
- Reset values: all outputs 0 and state IDLE. Reset acts immediately, including mid-transaction.
- IDLE, accepted when exValid=1 and flush=0:
  - Non-memory op: the wb register loads {1, exRdWrite, exRdAddr, exAddr, 0}.
  - Misaligned or reserved memory op: no request is issued. The wb register loads {wbValid=1, wbRdWrite=0, wbMisaligned=1}.
    - Misaligned means half with addr[0] set, or word with addr[1:0] nonzero.
  - Aligned memory op: the op fields and addr[1:0] are latched. dmemReq/We/Addr/WData/Be are registered, and state moves to BUSY. The wb register loads wbValid=0.
- IDLE with exValid=0 or flush=1: the wb register loads wbValid=0. All other wb fields also load 0.
- BUSY:
  - stall=1. The ex* inputs are ignored.
  - The dmem* outputs stay constant.
  - Each cycle without ack loads wbValid=0.
- BUSY with dmemAck=1, on the next edge:
  - dmemReq drops to 0 and state returns to IDLE.
  - A load writes the wb register with {1, latched rdWrite, latched rdAddr, extended data, 0}.
  - A store writes {1, 0, latched rdAddr, 0, 0}.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
- Store data: byte is {4{d[7:0]}}, half is {2{d[15:0]}}, word is d.
- Load extraction: byte lane is rdata[8*a+7 : 8*a], where a = addr[1:0]. Half lane is rdata[16*a[1]+15 : 16*a[1]]. The lane is sign-extended, or zero-extended when exUnsigned=1.
- Flush while BUSY: the bus transaction is never aborted, because of store side effects. A sticky killed flag is set. On ack the wb register loads wbValid=0, and the flag clears. Flush and ack in the same cycle also discards the result.
- dmemAck while dmemReq=0 is ignored.

## Timing
- stall is purely state==BUSY, with no combinational path from the ex* inputs.
- Non-memory op: accepted at edge E0, visible on wb* after E0. Latency is 1.
- Memory op: dmemReq rises after E0. Ack in cycle k after E0 (k ≥ 1) gives wb* valid after edge E0+k and stall low in the same cycle. Minimum load-to-wb latency is 2 cycles.
- The instruction held upstream during BUSY is accepted on the first edge after returning to IDLE. No instruction is lost or duplicated.
- wbValid is high for exactly one cycle per completed instruction.

## Test plan
- ALU op: exAddr=0x1234, rd=5, rdWrite=1 → one cycle later wbValid=1, wbData=0x1234, wbRdAddr=5, stall never high.
- Signed byte load: addr=0x103, ack after 3 cycles, rdata=0x80AABBCC → dmemAddr=0x100, stall high for 3 cycles, wbData=0xFFFFFF80. Repeat with exUnsigned=1 → 0x00000080.
- Half store: addr=0x202, data=0xDEADBEEF → dmemWe=1, dmemBe=4'b1100, dmemWData=0xBEEFBEEF; after ack wbValid=1, wbRdWrite=0.
- Misaligned word load at addr 0x301 → dmemReq never asserted; next cycle wbValid=1, wbMisaligned=1, wbRdWrite=0.
- Flush during BUSY, then ack → dmemReq is held until ack and wbValid stays 0. A held back-to-back ALU op is accepted on the following edge and produces exactly one wbValid pulse.
- rst low mid-transaction → dmemReq, stall and all wb* go to 0 immediately. After release, a new load completes normally.
